// File: rtl/regfile_scoreboard.sv
// Eight-entry register file with same-cycle write bypass and a per-register
// pending-write scoreboard that flags RAW hazards to the decode stage.

module regfile_scoreboard_checker #(
  parameter int DATA_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  input logic              err,
  input logic              writeEn,
  input logic [2:0]        writeReg,
  input logic [DATA_W-1:0] writeData,
  input logic [2:0]        read1reg,
  input logic [2:0]        read2reg,
  input logic [DATA_W-1:0] read1data,
  input logic [DATA_W-1:0] read2data
);

  err_sticky_a: assert property (@(posedge clk) disable iff (!rst_n) err |=> err);

  bypass1_a: assert property (@(posedge clk)
    (writeEn && (writeReg == read1reg)) |-> (read1data == writeData));

  bypass2_a: assert property (@(posedge clk)
    (writeEn && (writeReg == read2reg)) |-> (read2data == writeData));

endmodule

module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        read1reg,
  input  logic [2:0]        read2reg,
  output logic [DATA_W-1:0] read1data,
  output logic [DATA_W-1:0] read2data,
  output logic              read1busy,
  output logic              read2busy,
  input  logic              issueEn,
  input  logic [2:0]        issueReg,
  input  logic              writeEn,
  input  logic [2:0]        writeReg,
  input  logic [DATA_W-1:0] writeData,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [DATA_W-1:0] regs_r    [NUM_REGS];
  logic [CNT_W-1:0]  cnt_r     [NUM_REGS];
  logic [CNT_W-1:0]  cnt_nxt_s [NUM_REGS];
  logic              err_r;
  logic              err_nxt_s;

  // A same-cycle write to the addressed register wins over storage.
  function automatic logic [DATA_W-1:0] read_f(
    input logic              we,
    input logic [2:0]        wr,
    input logic [DATA_W-1:0] wd,
    input logic [2:0]        ra,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] res;
    if (we && (wr == ra)) begin
      res = wd;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // One pending count is retired by a write landing this cycle.
  function automatic logic busy_f(
    input logic             we,
    input logic [2:0]       wr,
    input logic [2:0]       ra,
    input logic [CNT_W-1:0] cnt
  );
    logic res;
    if (cnt > CNT_ONE) begin
      res = 1'b1;
    end else if (cnt == CNT_ONE) begin
      res = !(we && (wr == ra));
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

  // Combinational read ports with bypass and hazard indication.
  always_comb begin
    read1data = read_f(writeEn, writeReg, writeData, read1reg, regs_r[read1reg]);
    read2data = read_f(writeEn, writeReg, writeData, read2reg, regs_r[read2reg]);
    read1busy = busy_f(writeEn, writeReg, read1reg, cnt_r[read1reg]);
    read2busy = busy_f(writeEn, writeReg, read2reg, cnt_r[read2reg]);
  end

  // Next pending counts; overflow saturates, underflow holds at zero, both flag err.
  always_comb begin
    logic inc_v;
    logic dec_v;
    inc_v     = 1'b0;
    dec_v     = 1'b0;
    err_nxt_s = err_r;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_v        = issueEn && (issueReg == 3'(r));
      dec_v        = writeEn && (writeReg == 3'(r));
      cnt_nxt_s[r] = cnt_r[r];
      case ({inc_v, dec_v})
        2'b10: begin
          if (cnt_r[r] == CNT_MAX) begin
            err_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s[r] = cnt_r[r] + CNT_ONE;
          end
        end
        2'b01: begin
          if (cnt_r[r] == CNT_ZERO) begin
            err_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s[r] = cnt_r[r] - CNT_ONE;
          end
        end
        default: begin
          cnt_nxt_s[r] = cnt_r[r];
        end
      endcase
    end
  end

  // Register storage, scoreboard counters and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= {DATA_W{1'b0}};
        cnt_r[r]  <= CNT_ZERO;
      end
      err_r <= 1'b0;
    end else begin
      if (writeEn) begin
        regs_r[writeReg] <= writeData;
      end else begin
        regs_r[writeReg] <= regs_r[writeReg];
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_r[r] <= cnt_nxt_s[r];
      end
      err_r <= err_nxt_s;
    end
  end

  assign err = err_r;

  regfile_scoreboard_checker #(.DATA_W(DATA_W)) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .err       (err),
    .writeEn   (writeEn),
    .writeReg  (writeReg),
    .writeData (writeData),
    .read1reg  (read1reg),
    .read2reg  (read2reg),
    .read1data (read1data),
    .read2data (read2data)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against a behavioural model.

module tb_regfile_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [2:0]  read1reg, read2reg;
  logic [15:0] read1data, read2data;
  logic        read1busy, read2busy;
  logic        issueEn;
  logic [2:0]  issueReg;
  logic        writeEn;
  logic [2:0]  writeReg;
  logic [15:0] writeData;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] m_reg [8];
  int          m_cnt [8];
  logic        m_err;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .read1reg(read1reg), .read2reg(read2reg),
    .read1data(read1data), .read2data(read2data),
    .read1busy(read1busy), .read2busy(read2busy),
    .issueEn(issueEn), .issueReg(issueReg),
    .writeEn(writeEn), .writeReg(writeReg), .writeData(writeData),
    .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_data(input logic [2:0] a);
    if (writeEn && writeReg == a) return writeData;
    return m_reg[a];
  endfunction

  // Outstanding writes left after whatever lands this cycle.
  function automatic logic exp_busy(input logic [2:0] a);
    int left;
    left = m_cnt[a];
    if (writeEn && writeReg == a) left = left - 1;
    return left > 0;
  endfunction

  // Compare process: all outputs against the model every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      chk16("read1data", read1data, exp_data(read1reg));
      chk16("read2data", read2data, exp_data(read2reg));
      chk1("read1busy", read1busy, exp_busy(read1reg));
      chk1("read2busy", read2busy, exp_busy(read2reg));
      chk1("err", err, m_err);
    end
  end

  // Model update on each active edge.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int r = 0; r < 8; r++) begin
        int n;
        n = m_cnt[r];
        if (issueEn && issueReg == 3'(r)) n = n + 1;
        if (writeEn && writeReg == 3'(r)) n = n - 1;
        if (n > 3) begin n = 3; m_err = 1'b1; end
        if (n < 0) begin n = 0; m_err = 1'b1; end
        m_cnt[r] = n;
      end
      if (writeEn) m_reg[writeReg] = writeData;
    end
  end

  task automatic drive(input logic ie, input logic [2:0] ir, input logic we,
                       input logic [2:0] wr, input logic [15:0] wd,
                       input logic [2:0] r1, input logic [2:0] r2);
    issueEn = ie; issueReg = ir; writeEn = we; writeReg = wr; writeData = wd;
    read1reg = r1; read2reg = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    issueEn = 1'b0;
    writeEn = 1'b0;
    rst_n   = 1'b0;
    for (int r = 0; r < 8; r++) begin
      m_reg[r] = 16'h0000;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
    #1;
    chk16("rst_read1data", read1data, 16'h0000);
    chk16("rst_read2data", read2data, 16'h0000);
    chk1("rst_read1busy", read1busy, 1'b0);
    chk1("rst_read2busy", read2busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    do_reset();

    // write then read
    drive(1'b1, 3'd3, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3); tick();
    drive(1'b0, 3'd0, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3);
    chk1("wr_same_cycle_busy", read1busy, 1'b0); tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);
    chk16("wr_rd1", read1data, 16'hBEEF);
    chk16("wr_rd2", read2data, 16'hBEEF);
    chk1("wr_busy1", read1busy, 1'b0);
    chk1("wr_busy2", read2busy, 1'b0);
    tick();

    // bypass
    drive(1'b1, 3'd6, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd6); tick();
    drive(1'b1, 3'd7, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd6); tick();
    drive(1'b0, 3'd0, 1'b1, 3'd7, 16'h7777, 3'd7, 3'd6); tick();
    drive(1'b0, 3'd0, 1'b1, 3'd6, 16'h00A5, 3'd7, 3'd6);
    chk16("bypass_rd2", read2data, 16'h00A5);
    chk16("stored_rd1", read1data, 16'h7777);
    tick();

    // hazard lifecycle on reg4
    drive(1'b1, 3'd4, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd0);
    chk1("haz_c0_busy", read1busy, 1'b0); tick();
    drive(1'b1, 3'd4, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd0);
    chk1("haz_c1_busy", read1busy, 1'b1); tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd0);
    chk1("haz_c2_busy", read1busy, 1'b1); tick();
    drive(1'b0, 3'd0, 1'b1, 3'd4, 16'h0001, 3'd4, 3'd0);
    chk1("haz_c3_busy", read1busy, 1'b1); tick();
    drive(1'b0, 3'd0, 1'b1, 3'd4, 16'h0002, 3'd4, 3'd0);
    chk1("haz_c4_busy", read1busy, 1'b0);
    chk16("haz_c4_data", read1data, 16'h0002);
    tick();

    // simultaneous issue and write on reg1
    drive(1'b1, 3'd1, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd1); tick();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 16'h1111, 3'd1, 3'd1); tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd1);
    chk1("simul_busy", read1busy, 1'b1);
    chk1("simul_err", err, 1'b0);
    tick();
    drive(1'b0, 3'd0, 1'b1, 3'd1, 16'h2222, 3'd1, 3'd1); tick();

    // overflow on reg0
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0); tick();
      if (i == 2) chk1("ovf_err_before", err, 1'b0);
    end
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0);
    chk1("ovf_err", err, 1'b1);
    chk1("ovf_busy", read1busy, 1'b1);

    // legal traffic keeps err; set up cnt[2]=1 and reg5=0x1234
    drive(1'b1, 3'd5, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd2); tick();
    drive(1'b0, 3'd0, 1'b1, 3'd5, 16'h1234, 3'd5, 3'd2); tick();
    drive(1'b1, 3'd2, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd2); tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd2);
    chk16("pre_rst_rd1", read1data, 16'h1234);
    chk1("pre_rst_busy2", read2busy, 1'b1);
    chk1("err_sticky", err, 1'b1);
    do_reset();

    // underflow after reset
    drive(1'b0, 3'd0, 1'b1, 3'd2, 16'h2222, 3'd5, 3'd2);
    chk1("unf_err_before", err, 1'b0); tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd5);
    chk1("unf_err", err, 1'b1);
    chk16("unf_rd1", read1data, 16'h2222);
    chk16("unf_rd2", read2data, 16'h0000);
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              16'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
